icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  Miss handler between the I-cache lookup stage and the line memory (mem_sim).
//  Accepts one miss at a time and issues a line-aligned 128-bit refill request.
//  Captures the returned line, writes it into the cache data/tag arrays and
//  returns the critical 32-bit word. A timeout guards against a memory that never answers.
// PARAMETERS
//  ADDR_W   32  byte address width
//  LINE_W   128 cache line width in bits (4 words, 16 B)
//  INDEX_W  6   set index width (64 sets)
//  TIMEOUT  64  max cycles in REQ before error (>=2)
// PORTS
//  clk        in  1        single clock, rising edge
//  rst_n      in  1        asynchronous, active-low reset
//  miss_valid in  1        lookup stage presents a miss
//  miss_ready out 1        controller can accept a miss (IDLE only)
//  miss_addr  in  ADDR_W   byte address of missing fetch
//  mem_req    out 1        refill request, level, held until mem_ready
//  mem_addr   out ADDR_W   line-aligned request address
//  mem_data   in  LINE_W   returned line, valid when mem_ready=1
//  mem_ready  in  1        memory response strobe (one cycle)
//  fill_we    out 1        one-cycle write strobe to data/tag arrays
//  fill_index out INDEX_W  set index of fill
//  fill_tag   out ADDR_W-INDEX_W-4  tag of fill
//  fill_data  out LINE_W   line to write
//  rsp_valid  out 1        one-cycle response to fetch stage
//  rsp_word   out 32       critical word
//  rsp_err    out 1        qualifies rsp_valid: refill timed out
//  busy       out 1        state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0 except miss_ready=1.
//    Any in-flight refill is dropped; a later mem_ready is ignored.
//  - States: IDLE -> REQ -> FILL -> IDLE; REQ -> ERR -> IDLE on timeout.
//  - IDLE: miss_ready=1. On miss_valid, latch miss_addr and go to REQ.
//    mem_req=1 from the next cycle (T+1).
//  - REQ: mem_req=1; mem_addr={addr[31:4],4'b0}, stable throughout.
//    - Timeout counter clears on entry and increments each REQ cycle.
//    - If mem_ready=1: capture mem_data and go to FILL.
//    - Else if count==TIMEOUT-1: go to ERR.
//    - mem_ready and the timeout in the same cycle: mem_ready wins.
//  - FILL (one cycle; mem_ready sampled at R gives FILL at R+1):
//    - mem_req=0, fill_we=1, rsp_valid=1, rsp_err=0.
//    - fill_index=addr[INDEX_W+3:4]; fill_tag=addr[ADDR_W-1:INDEX_W+4].
//    - rsp_word=line[32*addr[3:2] +: 32].
//  - ERR (one cycle): mem_req=0, rsp_valid=1, rsp_err=1, fill_we=0, rsp_word=0.
//  - miss_ready returns at R+2 / E+1. Back-to-back misses therefore
//    need >= 3 cycles each.
//  - miss_valid while busy: not accepted (miss_ready=0); requester holds it.
//  - mem_ready outside REQ: ignored, no state change.
//  - Address low bits [3:0] are ignored for mem_addr; [3:2] select the word.
// STRUCTURE
//  - Shared pkg icache_pkg: LINE_W, WORD_W=32, OFFSET_W=4, INDEX_W,
//    TAG_W; typedef refill_state_e {IDLE,REQ,FILL,ERR}.
//  - Single module; timeout counter inline ($clog2(TIMEOUT) bits).
//  - No sub-module needed.
// TESTING
//  1. Miss 0x0000_1234, mem_ready 3 cycles later with line 0xDDDD..CCCC..BBBB..AAAA:
//     - mem_addr=0x0000_1230.
//     - fill_we at R+1, fill_index=0x23, fill_tag=0x000004.
//     - rsp_word=word1 (0xBBBBBBBB).
//  2. Word select sweep: miss_addr[3:2]=0..3 -> rsp_word = words 0..3 of the
//     line respectively.
//  3. No mem_ready, TIMEOUT=64:
//     - mem_req high for exactly 64 cycles.
//     - rsp_valid&rsp_err one cycle, fill_we never asserted.
//  4. mem_ready on the 64th REQ cycle -> FILL taken, rsp_err=0.
//  5. Second miss_valid held during a refill:
//     - miss_ready=0 until R+2; second miss accepted then.
//     - mem_addr switches only after the first mem_req drops.
//  6. rst_n low mid-REQ, then mem_ready pulse:
//     - Outputs cleared immediately, no fill_we, no rsp_valid.
//     - miss_ready=1 after release.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry constants and refill FSM state type for the I-cache miss path.
package icache_pkg;
    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 128;
    localparam int WORD_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 6;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL, ERR} refill_state_e;
endpackage

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: one-at-a-time I-cache miss handler; issues a line refill,
// writes the returned line into the arrays and answers with the critical word or a timeout error.
module icache_refill_ctrl #(
    parameter int ADDR_W  = icache_pkg::ADDR_W,
    parameter int LINE_W  = icache_pkg::LINE_W,
    parameter int INDEX_W = icache_pkg::INDEX_W,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss_valid,
    output logic                      miss_ready,
    input  logic [ADDR_W-1:0]         miss_addr,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [LINE_W-1:0]         mem_data,
    input  logic                      mem_ready,
    output logic                      fill_we,
    output logic [INDEX_W-1:0]        fill_index,
    output logic [ADDR_W-INDEX_W-5:0] fill_tag,
    output logic [LINE_W-1:0]         fill_data,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_word,
    output logic                      rsp_err,
    output logic                      busy
);
    import icache_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT);

    refill_state_e     state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;

    assign miss_ready = state == IDLE;
    assign busy       = state != IDLE;
    assign mem_addr   = {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign fill_index = addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign fill_tag   = addr[ADDR_W-1:INDEX_W+OFFSET_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            fill_we   <= 1'b0;
            fill_data <= '0;
            rsp_valid <= 1'b0;
            rsp_word  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            fill_we   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_word  <= '0;
            case (state)
                IDLE: if (miss_valid) begin
                    addr    <= miss_addr;
                    count   <= '0;
                    mem_req <= 1'b1;
                    state   <= REQ;
                end
                // A response in the final timeout cycle still completes the refill.
                REQ: if (mem_ready) begin
                    fill_data <= mem_data;
                    rsp_word  <= mem_data[32'(addr[3:2]) * WORD_W +: WORD_W];
                    fill_we   <= 1'b1;
                    rsp_valid <= 1'b1;
                    mem_req   <= 1'b0;
                    state     <= FILL;
                end else if (count == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    mem_req   <= 1'b0;
                    state     <= ERR;
                end else begin
                    count <= count + 1'b1;
                end
                FILL:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized scenario bench for icache_refill_ctrl against
// an address/line arithmetic reference model.
module tb_icache_refill_ctrl;
    logic         clk = 0, rst_n = 0, miss_valid = 0, mem_ready = 0;
    logic [31:0]  miss_addr = 0;
    logic [127:0] mem_data = 0;
    logic         miss_ready, mem_req, fill_we, rsp_valid, rsp_err, busy;
    logic [31:0]  mem_addr, rsp_word;
    logic [5:0]   fill_index;
    logic [21:0]  fill_tag;
    logic [127:0] fill_data;

    int vectors = 0, miscompares = 0;

    // Observations of the most recent refill made by do_miss
    logic [31:0]  o_maddr, o_word;
    logic [5:0]   o_idx;
    logic [21:0]  o_tag;
    logic [127:0] o_data;
    logic         o_stable, o_we, o_rv, o_re, o_mr_fill, o_mr_after;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_data(fill_data), .rsp_valid(rsp_valid), .rsp_word(rsp_word), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, required completion");
        $fatal(1);
    end

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] m_line_addr(logic [31:0] a);
        return a & ~32'hF;
    endfunction

    function automatic logic [5:0] m_index(logic [31:0] a);
        return 6'((a / 16) % 64);
    endfunction

    function automatic logic [21:0] m_tag(logic [31:0] a);
        return 22'(a / 1024);
    endfunction

    function automatic logic [31:0] m_word(logic [127:0] l, logic [31:0] a);
        return 32'(l >> (32 * ((a / 4) % 4)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one refill: d REQ cycles without response, then mem_ready on REQ cycle d+1
    task automatic do_miss(input logic [31:0] a, input logic [127:0] l, input int d);
        int n = 0;
        while (!miss_ready && n < 100) begin step(); n++; end
        miss_valid = 1; miss_addr = a;
        step();
        miss_valid = 0; miss_addr = $urandom;
        o_maddr = mem_addr;
        o_stable = mem_req;
        repeat (d) begin
            step();
            o_stable = o_stable & mem_req & (mem_addr == o_maddr);
        end
        mem_ready = 1; mem_data = l;
        step();
        mem_ready = 0; mem_data = rand_line();
        o_we = fill_we; o_idx = fill_index; o_tag = fill_tag; o_data = fill_data;
        o_rv = rsp_valid; o_re = rsp_err; o_word = rsp_word; o_mr_fill = miss_ready;
        step();
        o_mr_after = miss_ready;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({mem_req, fill_we, rsp_valid, rsp_err, busy, miss_ready} !== 6'b000001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 000001", {mem_req, fill_we, rsp_valid, rsp_err, busy, miss_ready});
        end
        vectors++;
        if ({mem_addr, rsp_word, fill_index, fill_tag, fill_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: mem_addr=%h rsp_word=%h idx=%h tag=%h required all 0", mem_addr, rsp_word, fill_index, fill_tag);
        end
        @(negedge clk) rst_n = 1;
        step();
    endtask

    task automatic test_basic();
        logic [127:0] l = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        do_miss(32'h0000_1234, l, 2);
        vectors++;
        if (o_maddr !== 32'h0000_1230 || !o_stable) begin
            miscompares++;
            $display("FAIL basic_mem_addr: got %h stable=%b required 00001230 stable=1", o_maddr, o_stable);
        end
        vectors++;
        if ({o_we, o_rv, o_re, o_mr_fill} !== 4'b1100) begin
            miscompares++;
            $display("FAIL basic_strobes: we/rv/err/ready got %b required 1100", {o_we, o_rv, o_re, o_mr_fill});
        end
        vectors++;
        if (o_idx !== 6'h23 || o_tag !== 22'h4) begin
            miscompares++;
            $display("FAIL basic_index_tag: got idx=%h tag=%h required 23 / 000004", o_idx, o_tag);
        end
        vectors++;
        if (o_word !== 32'hBBBBBBBB || o_data !== l) begin
            miscompares++;
            $display("FAIL basic_word: got %h required bbbbbbbb (line match=%b)", o_word, o_data === l);
        end
        vectors++;
        if (!o_mr_after || fill_we || rsp_valid) begin
            miscompares++;
            $display("FAIL basic_return: miss_ready=%b fill_we=%b rsp_valid=%b required 1/0/0", o_mr_after, fill_we, rsp_valid);
        end
    endtask

    task automatic test_word_sweep();
        for (int w = 0; w < 4; w++) begin
            logic [31:0]  a = ($urandom & ~32'hF) | 32'(w * 4) | ($urandom % 4);
            logic [127:0] l = rand_line();
            do_miss(a, l, $urandom_range(0, 5));
            vectors++;
            if (o_word !== 32'(l >> (32 * w)) || o_maddr !== m_line_addr(a)) begin
                miscompares++;
                $display("FAIL word_sweep[%0d]: got word=%h addr=%h required %h / %h", w, o_word, o_maddr, 32'(l >> (32 * w)), m_line_addr(a));
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        logic we_seen = 0;
        miss_valid = 1; miss_addr = $urandom;
        step();
        miss_valid = 0;
        while (mem_req && n < 200) begin
            n++;
            we_seen = we_seen | fill_we;
            step();
        end
        vectors++;
        if (n != 64) begin
            miscompares++;
            $display("FAIL timeout_len: mem_req high %0d cycles, required 64", n);
        end
        vectors++;
        if ({rsp_valid, rsp_err, fill_we, we_seen, miss_ready} !== 5'b11000 || rsp_word !== 0) begin
            miscompares++;
            $display("FAIL timeout_err: valid/err/we/we_seen/ready got %b word=%h required 11000 / 0", {rsp_valid, rsp_err, fill_we, we_seen, miss_ready}, rsp_word);
        end
        step();
        vectors++;
        if ({miss_ready, rsp_valid, rsp_err, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL timeout_return: ready/valid/err/busy got %b required 1000", {miss_ready, rsp_valid, rsp_err, busy});
        end
    endtask

    task automatic test_late_ready();
        logic [31:0]  a = $urandom;
        logic [127:0] l = rand_line();
        do_miss(a, l, 63);
        vectors++;
        if ({o_stable, o_we, o_rv, o_re} !== 4'b1110 || o_word !== m_word(l, a)) begin
            miscompares++;
            $display("FAIL late_ready: stable/we/rv/err got %b word=%h required 1110 / %h", {o_stable, o_we, o_rv, o_re}, o_word, m_word(l, a));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  a = $urandom, b = $urandom;
        logic [127:0] lb = rand_line();
        int bad = 0;
        miss_valid = 1; miss_addr = a;
        step();
        miss_addr = b;
        repeat (3) begin
            if (miss_ready || !mem_req || mem_addr !== m_line_addr(a)) bad++;
            step();
            if (!miss_ready && mem_req && mem_addr === m_line_addr(a) && bad == 0 && !mem_ready) mem_ready = (mem_data == mem_data) && $urandom_range(0, 0) == 0 ? mem_ready : 1'b0;
        end
        vectors++;
        if (bad != 0 || !mem_req) begin
            miscompares++;
            $display("FAIL b2b_first_req: %0d bad REQ cycles, mem_req=%b required 0 / 1", bad, mem_req);
        end
        mem_ready = 1; mem_data = rand_line();
        step();
        mem_ready = 0;
        vectors++;
        if (miss_ready || !fill_we || fill_tag !== m_tag(a)) begin
            miscompares++;
            $display("FAIL b2b_fill: miss_ready=%b fill_we=%b tag=%h required 0/1/%h", miss_ready, fill_we, fill_tag, m_tag(a));
        end
        step();
        vectors++;
        if (!miss_ready || mem_req || mem_addr !== m_line_addr(a)) begin
            miscompares++;
            $display("FAIL b2b_gap: miss_ready=%b mem_req=%b addr=%h required 1/0/%h", miss_ready, mem_req, mem_addr, m_line_addr(a));
        end
        step();
        miss_valid = 0;
        vectors++;
        if (miss_ready || !mem_req || mem_addr !== m_line_addr(b)) begin
            miscompares++;
            $display("FAIL b2b_second: miss_ready=%b mem_req=%b addr=%h required 0/1/%h", miss_ready, mem_req, mem_addr, m_line_addr(b));
        end
        mem_ready = 1; mem_data = lb;
        step();
        mem_ready = 0;
        vectors++;
        if (rsp_word !== m_word(lb, b) || fill_index !== m_index(b)) begin
            miscompares++;
            $display("FAIL b2b_second_rsp: word=%h idx=%h required %h / %h", rsp_word, fill_index, m_word(lb, b), m_index(b));
        end
        step();
    endtask

    task automatic test_reset_mid_req();
        miss_valid = 1; miss_addr = $urandom | 32'h10;
        step();
        miss_valid = 0;
        repeat (3) step();
        vectors++;
        if (!busy || !mem_req) begin
            miscompares++;
            $display("FAIL rst_pre: busy=%b mem_req=%b required 1/1", busy, mem_req);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({mem_req, busy, miss_ready, fill_we, rsp_valid} !== 5'b00100 || mem_addr !== 0) begin
            miscompares++;
            $display("FAIL rst_async: req/busy/ready/we/valid got %b addr=%h required 00100 / 0", {mem_req, busy, miss_ready, fill_we, rsp_valid}, mem_addr);
        end
        @(negedge clk) rst_n = 1;
        mem_ready = 1; mem_data = rand_line();
        step();
        mem_ready = 0;
        step();
        vectors++;
        if ({miss_ready, busy, fill_we, rsp_valid, rsp_err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL rst_stale_ready: ready/busy/we/valid/err got %b required 10000", {miss_ready, busy, fill_we, rsp_valid, rsp_err});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [31:0]  a = $urandom;
            logic [127:0] l = rand_line();
            do_miss(a, l, $urandom_range(0, 12));
            vectors++;
            if (o_maddr !== m_line_addr(a) || !o_stable || o_idx !== m_index(a) || o_tag !== m_tag(a)) begin
                miscompares++;
                $display("FAIL rand[%0d]_addr: addr=%h idx=%h tag=%h stable=%b required %h/%h/%h/1", i, o_maddr, o_idx, o_tag, o_stable, m_line_addr(a), m_index(a), m_tag(a));
            end
            vectors++;
            if (o_word !== m_word(l, a) || o_data !== l || {o_we, o_rv, o_re, o_mr_fill, o_mr_after} !== 5'b11001) begin
                miscompares++;
                $display("FAIL rand[%0d]_rsp: word=%h flags=%b required %h / 11001", i, o_word, {o_we, o_rv, o_re, o_mr_fill, o_mr_after}, m_word(l, a));
            end
            if ($urandom_range(0, 1) == 1) begin
                mem_ready = 1;
                step();
                mem_ready = 0;
                vectors++;
                if ({busy, fill_we, rsp_valid, miss_ready} !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL rand[%0d]_idle_ready: busy/we/valid/ready got %b required 0001", i, {busy, fill_we, rsp_valid, miss_ready});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_word_sweep();
        test_timeout();
        test_late_ready();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
